// File: rtl/walk_request_arbiter.sv
// Debounced multi-channel walk-request latch with round-robin valid/ack offer.
// Optional wait-age tracking is built when WALK_AGE_EN is defined.
module walk_request_arbiter #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3,
  parameter int AGE_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                sys_reset,
  input  logic [CHANNELS-1:0] walkRequest_in,
  input  logic [CHANNELS-1:0] walkRegister_reset,
  output logic [CHANNELS-1:0] walkRegister_status,
  output logic                any_pending,
  output logic                serve_valid,
  output logic [CH_W-1:0]     serve_ch,
  input  logic                serve_ack,
  output logic [AGE_W-1:0]    max_age
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e              state_q;
  logic [CHANNELS-1:0] pend_q, pend_d, qual, clr, avail;
  logic [DB_W-1:0]     cnt_q [CHANNELS];
  logic [CH_W-1:0]     rr_q, ch_q, pick, rr_nxt;
  logic                valid_q, found, ack_ok, wdraw;

  assign wdraw  = (state_q == OFFER) && walkRegister_reset[ch_q];
  assign ack_ok = (state_q == OFFER) && serve_ack && !walkRegister_reset[ch_q];
  assign rr_nxt = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      qual[i] = walkRequest_in[i] && (cnt_q[i] == DB_LAST);
      clr[i]  = walkRegister_reset[i] || (ack_ok && ch_q == CH_W'(i));
    end
    pend_d = (pend_q | qual) & ~clr;
  end

  // First pending channel at or after rr_q, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    avail = pend_q & ~walkRegister_reset;
    for (int k = 0; k < CHANNELS; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && avail[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!walkRequest_in[i])     cnt_q[i] <= '0;
        else if (cnt_q[i] != DB_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            ch_q    <= pick;
          end
        end
        OFFER: begin
          if (wdraw) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (serve_ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rr_q    <= rr_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign walkRegister_status = pend_q;
  assign any_pending         = |pend_q;
  assign serve_valid         = valid_q;
  assign serve_ch            = ch_q;

`ifdef WALK_AGE_EN
  logic [AGE_W-1:0] age_q [CHANNELS];
  logic [AGE_W-1:0] max_d, max_q;

  always_comb begin
    max_d = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (pend_q[i] && age_q[i] > max_d) max_d = age_q[i];
  end

  // Age restarts at 0 on a fresh request and drops to 0 once cleared
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      max_q <= '0;
      for (int i = 0; i < CHANNELS; i++) age_q[i] <= '0;
    end else begin
      max_q <= max_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!(pend_d[i] && pend_q[i])) age_q[i] <= '0;
        else if (age_q[i] != '1)      age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  assign max_age = max_q;
`else
  assign max_age = '0;
`endif

endmodule

// File: tb/tb_walk_request_arbiter.sv
// Directed bench for walk_request_arbiter with an in-bench reference model.
// Age expectations follow WALK_AGE_EN.
module tb_walk_request_arbiter;

  localparam int CH  = 4;
  localparam int DB  = 3;
  localparam int AW  = 4;
  localparam int AMX = 15;
`ifdef WALK_AGE_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] req = '0;
  logic [CH-1:0] wr  = '0;
  logic          ack = 1'b0;
  logic [CH-1:0] status;
  logic          anyp, valid;
  logic [1:0]    sch;
  logic [AW-1:0] mage;

  int checks = 0;
  int failures = 0;

  walk_request_arbiter #(.CHANNELS(CH), .DEBOUNCE(DB), .AGE_W(AW)) dut (
    .clk(clk), .sys_reset(rst),
    .walkRequest_in(req), .walkRegister_reset(wr),
    .walkRegister_status(status), .any_pending(anyp),
    .serve_valid(valid), .serve_ch(sch), .serve_ack(ack),
    .max_age(mage)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // Reference model in plain integers
  int m_cnt[CH];
  bit m_pend[CH];
  int m_age[CH];
  bit m_off;
  int m_ch;
  int m_rr;
  int m_max;

  always @(posedge clk) begin
    bit np[CH];
    int nc[CH];
    bit q, ackok, wd, got;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_pend[i] = 0; m_age[i] = 0;
      end
      m_off = 0; m_ch = 0; m_rr = 0; m_max = 0;
    end else begin
      ackok = m_off && ack && !wr[m_ch];
      wd = m_off && wr[m_ch];
      m_max = 0;
      for (int i = 0; i < CH; i++)
        if (m_pend[i] && m_age[i] > m_max) m_max = m_age[i];
      for (int i = 0; i < CH; i++) begin
        q = req[i] && (m_cnt[i] == DB - 1);
        nc[i] = req[i] ? ((m_cnt[i] < DB) ? m_cnt[i] + 1 : DB) : 0;
        np[i] = (m_pend[i] || q) && !wr[i] && !(ackok && m_ch == i);
        if (np[i] && m_pend[i]) m_age[i] = (m_age[i] < AMX) ? m_age[i] + 1 : AMX;
        else m_age[i] = 0;
      end
      if (!m_off) begin
        got = 0;
        for (int k = 0; k < CH; k++) begin
          int idx;
          idx = (m_rr + k) % CH;
          if (!got && m_pend[idx] && !wr[idx]) begin
            got = 1; m_off = 1; m_ch = idx;
          end
        end
      end else if (wd) begin
        m_off = 0;
      end else if (ack) begin
        m_off = 0;
        m_rr = (m_ch + 1) % CH;
      end
      for (int i = 0; i < CH; i++) begin
        m_pend[i] = np[i]; m_cnt[i] = nc[i];
      end
    end
  end

  always @(negedge clk) begin
    int ps;
    ps = 0;
    for (int i = 0; i < CH; i++) if (m_pend[i]) ps |= (1 << i);
    chk("m_status", int'(status), ps);
    chk("m_any", int'(anyp), int'(ps != 0));
    chk("m_valid", int'(valid), int'(m_off));
    if (m_off) chk("m_ch", int'(sch), m_ch);
    chk("m_age", int'(mage), AGE_ON ? m_max : 0);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic rr_round(input string tag);
    int exp_ch[3] = '{0, 2, 3};
    int w;
    req = 4'b1101; cyc(3); req = '0;
    chk({tag, "_pend"}, int'(status), 4'b1101);
    for (int g = 0; g < 3; g++) begin
      w = 0;
      while (!valid && w < 8) begin cyc(1); w++; end
      chk({tag, "_valid"}, int'(valid), 1);
      chk({tag, "_ch"}, int'(sch), exp_ch[g]);
      chk({tag, "_gap"}, w, 1);
      ack = 1'b1; cyc(1); ack = 1'b0;
      chk({tag, "_drop"}, int'(valid), 0);
    end
    chk({tag, "_empty"}, int'(status), 0);
  endtask

  initial begin
    rst = 1'b1; req = 4'hF;
    cyc(2);
    chk("rst_status", int'(status), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_any", int'(anyp), 0);
    chk("rst_age", int'(mage), 0);
    rst = 1'b0; req = '0; cyc(1);

    req = 4'b0010; cyc(2); req = '0; cyc(3);
    chk("pulse_ignored", int'(status), 0);

    req = 4'b0010; cyc(2);
    chk("press_early", int'(status), 0);
    cyc(1);
    chk("press_latency", int'(status), 4'b0010);
    chk("press_any", int'(anyp), 1);
    chk("press_no_offer_yet", int'(valid), 0);
    cyc(1);
    chk("offer_valid", int'(valid), 1);
    chk("offer_ch", int'(sch), 1);
    ack = 1'b1; cyc(1); ack = 1'b0;
    chk("ack_drop", int'(valid), 0);
    chk("ack_clear", int'(status), 0);
    cyc(3);
    chk("held_no_rerequest", int'(status), 0);
    req = '0; cyc(1);

    rst = 1'b1; cyc(1); rst = 1'b0;
    rr_round("rr1");
    rr_round("rr2");

    req = 4'b0100; cyc(3); req = '0; cyc(1);
    chk("wd_offer", int'(sch), 2);
    wr = 4'b0100; ack = 1'b1; cyc(1); wr = '0; ack = 1'b0;
    chk("wd_drop", int'(valid), 0);
    chk("wd_status", int'(status), 0);
    req = 4'b1001; cyc(3); req = '0; cyc(1);
    chk("wd_rr_kept", int'(sch), 0);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
    chk("wd_next", int'(sch), 3);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);

    req = 4'b0010; cyc(2); wr = 4'b0010; cyc(1); wr = '0;
    chk("collide_lost", int'(status), 0);
    cyc(2);
    chk("collide_no_rearm", int'(status), 0);
    chk("collide_idle", int'(valid), 0);
    req = '0; cyc(1);

    req = 4'b0001; cyc(3); req = '0;
    chk("age_pend", int'(status), 1);
    cyc(5);
    chk("age_mid", int'(mage), AGE_ON ? 4 : 0);
    cyc(15);
    chk("age_sat", int'(mage), AGE_ON ? 15 : 0);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
    chk("age_zero", int'(mage), 0);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
